ide_bus_target: RTL
===================

Name: ide_bus_target

Overview:
- 68000-side bus responder for the on-board IDE port. It decodes 68000 cycles (AS/UDS/LDS/RW) addressed to the IDE window and drives ATA PIO strobes (IDECS, IOR, IOW) with programmable setup, strobe and hold timing.
- Terminates each decoded cycle with DTACK; honours drive IORDY.
- Sits beside bus_top on the 68000-side bus, replacing the stub ata responder.

Parameters:
- BASE_HI, 8'hDA, value matched against A[23:16] for the IDE window.
- SETUP_CYC, 2, clocks from CS valid to IOR/IOW assertion (ATA t1); range 1..255.
- STROBE_CYC, 6, minimum clocks IOR/IOW held low (ATA t2); range 1..255.
- HOLD_CYC, 2, clocks CS held after strobe negation (ATA t9); range 1..255.
- TIMEOUT_CYC, 255, maximum clocks spent waiting on IORDY (used only with IDE_TIMEOUT_EN).

Ports:
- CLKCPU  in  1  clock; all logic rises on it.
- RESET  in  1  synchronous, active-high reset.
- AS  in  1  68000 address strobe, active low.
- UDS  in  1  upper data strobe, active low.
- LDS  in  1  lower data strobe, active low.
- RW  in  1  1 = read, 0 = write.
- A  in  24  68000 address bus.
- WAIT  in  1  drive IORDY; 0 = drive not ready.
- IDECS  out  2  ATA CS1/CS0, active low; [0] = CS0, [1] = CS1.
- IOR  out  1  ATA read strobe, active low.
- IOW  out  1  ATA write strobe, active low.
- DTACK  out  1  68000 data acknowledge, active low.
- ACCESS  out  1  low while the current cycle decodes to the IDE window; used to gate other responders.
- TIMEOUT  out  1  one-clock high pulse when an IORDY timeout occurs (IDE_TIMEOUT_EN only; otherwise tied 0).

Behaviour:
- Reset:
  - Clock and reset: one clock, CLKCPU; reset is synchronous and active-high, on RESET.
  - On RESET = 1 at a clock edge, on the next edge: IDECS = 2'b11, IOR = 1, IOW = 1, DTACK = 1, ACCESS = 1, TIMEOUT = 0, FSM = IDLE, counter = 0.
  - Reset mid-cycle drops all strobes immediately, with no hold phase.
- Input sampling: AS, UDS, LDS, RW, A and WAIT are registered once on CLKCPU. All decisions use the registered copies, which adds 1 clock of latency.
- Decode:
  - hit = !AS_r && (UDS_r==0 || LDS_r==0) && A_r[23:16]==BASE_HI && A_r[15:12] in {4'h2, 4'h3}.
  - A_r[15:12]==2 selects CS0; A_r[15:12]==3 selects CS1.
  - ACCESS = !hit, registered.
- FSM states:
  - IDLE: all outputs inactive. On hit: latch the CS select and RW, assert the chosen IDECS bit, load counter = SETUP_CYC, go to SETUP.
  - SETUP: decrement the counter. At 1: assert IOR if RW=1 or IOW if RW=0, load STROBE_CYC, go to STROBE.
  - STROBE: decrement the counter. At 1 with WAIT_r=1: go to HOLD. At 1 with WAIT_r=0: go to WAITRDY.
  - WAITRDY: hold the strobe. When WAIT_r=1: go to HOLD.
  - HOLD:
    - Entry negates IOR/IOW and loads HOLD_CYC; the counter decrements each clock.
    - For a completed transfer, DTACK asserts on HOLD entry, so read data from the drive is still valid on the 68000 bus.
    - At 1: negate IDECS and go to ACK.
  - ACK: keep DTACK low until AS_r = 1, then negate DTACK and go to IDLE.
- Back-to-back cycles: no new cycle starts until AS_r has been seen high, so each AS assertion produces exactly one transfer.
- Aborted cycle: if AS_r goes high in SETUP, STROBE or WAITRDY:
  - From SETUP: negate IDECS on the next edge and go to IDLE; no strobe is issued.
  - From STROBE or WAITRDY: negate the strobe and go to HOLD with DTACK held high, then go to IDLE. DTACK is never asserted.
- Counter: 8 bits. A parameter value of 1 gives exactly 1 clock in that phase. Values of 0 are illegal and are treated as 1.
- Byte lanes: UDS and LDS only qualify the decode. The data bus is not routed through this block.
- One-hot guarantee: IOR and IOW are never both low, and at most one IDECS bit is low.

Optional Feature:
- Macro: IDE_TIMEOUT_EN.
- Defined:
  - A second 8-bit counter runs in WAITRDY.
  - After TIMEOUT_CYC clocks with WAIT_r=0, the FSM proceeds to HOLD as a normal completion (DTACK asserted), and TIMEOUT pulses high for 1 clock.
- Not defined: WAITRDY waits indefinitely on WAIT; TIMEOUT is constant 0.

Test Plan:
- Read, CS0: RESET for 2 clocks, then a cycle with A=24'hDA2000, RW=1, UDS=LDS=0, WAIT=1.
  - IDECS=2'b10 on the clock after the registered hit.
  - IOR low 2 clocks later for exactly 6 clocks; IOW stays 1.
  - DTACK low at HOLD entry; IDECS=11 2 clocks later.
  - DTACK high 1 clock after AS_r goes high.
- Write, CS1 with stall: A=24'hDA3004, RW=0, WAIT held 0 for 10 clocks after the strobe starts.
  - IDECS=2'b01.
  - IOW low for 6+10(+1 sync) clocks.
  - DTACK only after WAIT_r=1.
- Non-hit: A=24'hDA4000 and A=24'hBF2000 cycles → ACCESS, IDECS, IOR, IOW and DTACK all stay 1.
- Abort: AS negated in the 3rd STROBE clock → IOR high on the next edge; IDECS high after HOLD_CYC; DTACK never low.
- Reset mid-strobe: RESET asserted during STROBE → next edge: IOR=1, IDECS=11, DTACK=1, FSM=IDLE. A new hit after reset completes normally.
- With IDE_TIMEOUT_EN and TIMEOUT_CYC=16: WAIT held 0 → after 16 WAITRDY clocks, TIMEOUT is a 1-clock pulse, DTACK goes low, and the cycle completes.

Source files
------------

// File: rtl/ide_bus_target.sv
// 68000-side IDE responder: decodes the IDE window and sequences the ATA PIO CS/IOR/IOW strobes.
// Define IDE_TIMEOUT_EN to bound the IORDY wait and pulse TIMEOUT when the bound expires.
module ide_bus_target #(
  parameter logic [7:0] BASE_HI     = 8'hDA,
  parameter int         SETUP_CYC   = 2,
  parameter int         STROBE_CYC  = 6,
  parameter int         HOLD_CYC    = 2,
  parameter int         TIMEOUT_CYC = 255
) (
  input  logic        CLKCPU,
  input  logic        RESET,
  input  logic        AS,
  input  logic        UDS,
  input  logic        LDS,
  input  logic        RW,
  input  logic [23:0] A,
  input  logic        WAIT,
  output logic [1:0]  IDECS,
  output logic        IOR,
  output logic        IOW,
  output logic        DTACK,
  output logic        ACCESS,
  output logic        TIMEOUT
);

  typedef enum logic [2:0] {IDLE, SETUP, STROBE, WAITRDY, HOLD, ACK} state_t;

  // A phase length of 0 behaves as 1.
  localparam logic [7:0] SETUP_LD  = (SETUP_CYC  < 1) ? 8'd1 : 8'(SETUP_CYC);
  localparam logic [7:0] STROBE_LD = (STROBE_CYC < 1) ? 8'd1 : 8'(STROBE_CYC);
  localparam logic [7:0] HOLD_LD   = (HOLD_CYC   < 1) ? 8'd1 : 8'(HOLD_CYC);

  logic       as_q, uds_q, lds_q, rw_in_q, wait_q;
  logic [7:0] a_hi_q;
  logic [3:0] a_sel_q;

  always_ff @(posedge CLKCPU) begin
    as_q    <= AS;
    uds_q   <= UDS;
    lds_q   <= LDS;
    rw_in_q <= RW;
    wait_q  <= WAIT;
    a_hi_q  <= A[23:16];
    a_sel_q <= A[15:12];
  end

  logic hit;
  assign hit = !as_q && (!uds_q || !lds_q) && (a_hi_q == BASE_HI) &&
               ((a_sel_q == 4'h2) || (a_sel_q == 4'h3));

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [1:0] idecs_q, idecs_d;
  logic       ior_q, ior_d, iow_q, iow_d, dtack_q, dtack_d, access_q, access_d;
  logic       rw_q, rw_d, abort_q, abort_d, armed_q, armed_d;
  logic       enter_hold;

`ifdef IDE_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_LD = (TIMEOUT_CYC < 1) ? 8'd1 : 8'(TIMEOUT_CYC);
  logic [7:0] tcnt_q, tcnt_d;
  logic       timeout_q, timeout_d;
  logic       unused_addr;
  assign unused_addr = ^A[11:0];
  assign TIMEOUT = timeout_q;
`else
  logic unused_cfg;
  assign unused_cfg = ^{A[11:0], 8'(TIMEOUT_CYC)};
  assign TIMEOUT = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idecs_d    = idecs_q;
    ior_d      = ior_q;
    iow_d      = iow_q;
    dtack_d    = dtack_q;
    rw_d       = rw_q;
    abort_d    = abort_q;
    armed_d    = armed_q | as_q;  // a new transfer needs AS seen high first
    access_d   = !hit;
    enter_hold = 1'b0;
`ifdef IDE_TIMEOUT_EN
    tcnt_d     = tcnt_q;
    timeout_d  = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        idecs_d = 2'b11;
        ior_d   = 1'b1;
        iow_d   = 1'b1;
        dtack_d = 1'b1;
        if (hit && armed_q) begin
          idecs_d = a_sel_q[0] ? 2'b01 : 2'b10;
          rw_d    = rw_in_q;
          cnt_d   = SETUP_LD;
          armed_d = 1'b0;
          abort_d = 1'b0;
          state_d = SETUP;
        end
      end
      SETUP: begin
        if (as_q) begin
          idecs_d = 2'b11;
          state_d = IDLE;
        end else if (cnt_q <= 8'd1) begin
          ior_d   = !rw_q;
          iow_d   = rw_q;
          cnt_d   = STROBE_LD;
          state_d = STROBE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      STROBE: begin
        if (as_q || (cnt_q <= 8'd1 && wait_q)) begin
          enter_hold = 1'b1;
        end else if (cnt_q <= 8'd1) begin
          state_d = WAITRDY;
`ifdef IDE_TIMEOUT_EN
          tcnt_d  = TIMEOUT_LD;
`endif
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      WAITRDY: begin
        if (as_q || wait_q) begin
          enter_hold = 1'b1;
        end else begin
`ifdef IDE_TIMEOUT_EN
          if (tcnt_q <= 8'd1) begin
            enter_hold = 1'b1;
            timeout_d  = 1'b1;
          end else begin
            tcnt_d = tcnt_q - 8'd1;
          end
`endif
        end
      end
      HOLD: begin
        if (cnt_q <= 8'd1) begin
          idecs_d = 2'b11;
          state_d = abort_q ? IDLE : ACK;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      ACK: begin
        if (as_q) begin
          dtack_d = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // AS already released here means an abort: DTACK stays high, HOLD exits to IDLE.
    if (enter_hold) begin
      ior_d   = 1'b1;
      iow_d   = 1'b1;
      cnt_d   = HOLD_LD;
      abort_d = as_q;
      dtack_d = as_q;
      state_d = HOLD;
    end
  end

  always_ff @(posedge CLKCPU) begin
    if (RESET) begin
      state_q   <= IDLE;
      cnt_q     <= 8'd0;
      idecs_q   <= 2'b11;
      ior_q     <= 1'b1;
      iow_q     <= 1'b1;
      dtack_q   <= 1'b1;
      access_q  <= 1'b1;
      rw_q      <= 1'b1;
      abort_q   <= 1'b0;
      armed_q   <= 1'b0;
`ifdef IDE_TIMEOUT_EN
      tcnt_q    <= 8'd0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idecs_q   <= idecs_d;
      ior_q     <= ior_d;
      iow_q     <= iow_d;
      dtack_q   <= dtack_d;
      access_q  <= access_d;
      rw_q      <= rw_d;
      abort_q   <= abort_d;
      armed_q   <= armed_d;
`ifdef IDE_TIMEOUT_EN
      tcnt_q    <= tcnt_d;
      timeout_q <= timeout_d;
`endif
    end
  end

  assign IDECS  = idecs_q;
  assign IOR    = ior_q;
  assign IOW    = iow_q;
  assign DTACK  = dtack_q;
  assign ACCESS = access_q;

endmodule
